ijtag_scan_driver: RTL and testbench
====================================

// Module: ijtag_scan_driver
// PURPOSE
//  Host-side initiator for the secure IJTAG network: runs one full CSU scan (capture, shift, update)
//  into the chain of secure SIBs. Drives Select, CaptureEN, ShiftEN and UpdateEn plus serial SI; collects serial SO.
//  Sits between the test controller (or key-loading logic) and the first SIB of the network.
//  Used to open and close SIBs and to shift key/data patterns. Returns the bits shifted out.
// PARAMETERS
//  MAX_LEN   64                       max scan length in bits per operation
//  CNT_W     $clog2(MAX_LEN+1)        width of Len / bit counter
// PORTS
//  Clock      in   1         single clock; all state changes on rising edge
//  RstBar     in   1         synchronous, active-low reset
//  Start      in   1         request one scan; sampled only in IDLE
//  Len        in   CNT_W     number of shift cycles; sampled with Start
//  WrData     in   MAX_LEN   bits to shift in, bit 0 first; sampled with Start
//  Busy       out  1         high from cycle after accepted Start until DONE exits
//  Done       out  1         one-cycle pulse when RdData is valid
//  RdData     out  MAX_LEN   shifted-out bits, first-out at bit 0, bits >= Len zero
//  NetSO      in   1         serial output of last SIB in the network
//  NetSI      out  1         serial input to first SIB in the network
//  Select     out  1         network select
//  CaptureEN  out  1         capture strobe
//  ShiftEN    out  1         shift enable
//  UpdateEn   out  1         update strobe
//  Abort      in   1         only with SCAN_DRV_ABORT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (RstBar=0 at edge): state IDLE; Busy, Done, Select, CaptureEN, ShiftEN, UpdateEn, NetSI = 0.
//    RdData = 0. Counter = 0. Reset mid-scan abandons the scan; no UpdateEn is issued.
//  - FSM states and transitions:
//    IDLE -> CAPTURE on Start. Latch Len (clamped to MAX_LEN) and WrData into the shift register.
//    CAPTURE (1 cycle): Select=1, CaptureEN=1. Next state is SHIFT if Len>0, else UPDATE.
//    SHIFT (Len cycles): Select=1, ShiftEN=1. NetSI = shift-reg bit 0.
//      Each edge: sample NetSO into the shift-reg MSB and shift right; counter++.
//    SHIFT -> UPDATE when counter reaches Len.
//    UPDATE (1 cycle): Select=1, UpdateEn=1; shift reg right-aligned by (MAX_LEN-Len).
//    DONE (1 cycle): Done=1; RdData loaded; -> IDLE.
//  - Control outputs are registered and one-hot per state; never two strobes high together.
//  - NetSI and all strobes are 0 outside CAPTURE/SHIFT/UPDATE.
//  - Start while Busy: ignored, with no queueing. Start during the DONE cycle is also ignored.
//  - Minimum turnaround: Start -> Done = Len+3 cycles. Back-to-back Start is accepted in the cycle after DONE.
//  - Len > MAX_LEN: clamped to MAX_LEN. Len = 0: capture+update only, RdData = 0.
//  - RdData holds its value until the next DONE or reset.
// CONFIGURATION
//  SCAN_DRV_ABORT_EN defined: Abort port exists.
//    Abort=1 in CAPTURE or SHIFT -> next state IDLE, all strobes 0, no UpdateEn, no Done, RdData unchanged.
//    Abort in UPDATE/DONE/IDLE is ignored. Purpose: abandon a wrong key pattern without committing it.
//  SCAN_DRV_ABORT_EN undefined: no Abort port; scans always run to completion.
// STRUCTURE
//  ijtag_pkg: typedef enum scan_state_t {IDLE,CAPTURE,SHIFT,UPDATE,DONE}; localparam IJTAG_MAX_LEN_DFLT=64.
//  Sub-module ijtag_shreg: MAX_LEN-bit parallel-load, serial-in/serial-out right shift register with align-on-update.
//  Top holds the FSM, counter and output registers.
// TESTING  (bench MAX_LEN=8; network model = N-flop serial chain, SO=last flop)
//  1. Reset: hold RstBar=0 3 cycles with Start=1 -> all outputs 0, no strobes.
//  2. Len=3, WrData=8'b101, 3-flop chain preloaded 3'b110 -> CaptureEN 1 cycle, ShiftEN 3 cycles,
//     NetSI seq 1,0,1, UpdateEn 1 cycle, Done at Start+6, RdData=8'b011 (first-out at bit 0), chain=101.
//  3. Len=0 -> CaptureEN, UpdateEn, Done at Start+3, RdData=0, ShiftEN never high.
//  4. Len=12 -> clamped: exactly 8 ShiftEN cycles, Done at Start+11.
//     Second Start issued mid-scan -> ignored, one Done only.
//  5. RstBar=0 during 2nd shift cycle -> next cycle IDLE, UpdateEn never asserted, RdData=0.
//  6. SCAN_DRV_ABORT_EN build: Abort in 2nd shift cycle of Len=4 -> IDLE, no UpdateEn, no Done, RdData keeps old value.

Source files
------------

// File: rtl/ijtag_pkg.sv
// Shared types for the IJTAG scan driver: FSM state encoding and the strobe bundle.
// Optional abort support in the top is enabled with `define SCAN_DRV_ABORT_EN.
package ijtag_pkg;

  localparam int IJTAG_MAX_LEN_DFLT = 64;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    UPDATE,
    DONE
  } scan_state_t;

  typedef struct packed {
    logic select;
    logic capture_en;
    logic shift_en;
    logic update_en;
  } scan_ctrl_t;

  // Network strobes for a given state; at most one of capture/shift/update is ever set.
  function automatic scan_ctrl_t ctrl_for(scan_state_t s);
    scan_ctrl_t c;
    c = '0;
    case (s)
      CAPTURE: begin
        c.select     = 1'b1;
        c.capture_en = 1'b1;
      end
      SHIFT: begin
        c.select   = 1'b1;
        c.shift_en = 1'b1;
      end
      UPDATE: begin
        c.select    = 1'b1;
        c.update_en = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ijtag_shreg.sv
// Parallel-load, serial-in/serial-out right shift register. Serial data enters at the MSB,
// leaves at bit 0; align moves the last len captured bits down to bit 0 with zero fill.
module ijtag_shreg
  import ijtag_pkg::*;
#(
  parameter int MAX_LEN = IJTAG_MAX_LEN_DFLT,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_bar,
  input  logic               load,
  input  logic               shift,
  input  logic               align,
  input  logic [MAX_LEN-1:0] load_data,
  input  logic               ser_in,
  input  logic [CNT_W-1:0]   len,
  output logic               ser_out,
  output logic [MAX_LEN-1:0] aligned
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

  logic [MAX_LEN-1:0] data_reg;
  logic [MAX_LEN-1:0] shift_next;
  logic [CNT_W-1:0]   align_amt;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_bit
      if (gi == MAX_LEN - 1) begin : g_top
        assign shift_next[gi] = ser_in;
      end else begin : g_mid
        assign shift_next[gi] = data_reg[gi+1];
      end
    end
  endgenerate

  // After len shifts the captured bits sit in the top len positions, first-out lowest.
  assign align_amt = LEN_MAX - len;
  assign aligned   = data_reg >> align_amt;
  assign ser_out   = data_reg[0];

  always_ff @(posedge clk) begin
    if (!rst_bar) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= load_data;
    end else if (shift) begin
      data_reg <= shift_next;
    end else if (align) begin
      data_reg <= aligned;
    end
  end

endmodule

// File: rtl/ijtag_scan_driver.sv
// Host-side IJTAG scan initiator: one capture/shift/update pass through the SIB chain per Start.
// Define SCAN_DRV_ABORT_EN to add the Abort input that abandons a scan before update.
module ijtag_scan_driver
  import ijtag_pkg::*;
#(
  parameter int MAX_LEN = IJTAG_MAX_LEN_DFLT,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               Clock,
  input  logic               RstBar,
  input  logic               Start,
  input  logic [CNT_W-1:0]   Len,
  input  logic [MAX_LEN-1:0] WrData,
  output logic               Busy,
  output logic               Done,
  output logic [MAX_LEN-1:0] RdData,
  input  logic               NetSO,
  output logic               NetSI,
  output logic               Select,
  output logic               CaptureEN,
  output logic               ShiftEN,
  output logic               UpdateEn
`ifdef SCAN_DRV_ABORT_EN
  ,
  input  logic               Abort
`endif
);

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

  scan_state_t        state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [CNT_W-1:0]   len_reg, len_next;
  scan_ctrl_t         ctrl_reg;
  logic               busy_reg, done_reg;
  logic [MAX_LEN-1:0] rd_data_reg;

  logic               abort_req;
  logic               sh_load, sh_shift, sh_align, sh_out;
  logic [MAX_LEN-1:0] sh_aligned;

`ifdef SCAN_DRV_ABORT_EN
  assign abort_req = Abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          state_next = CAPTURE;
          cnt_next   = '0;
          len_next   = (Len > LEN_MAX) ? LEN_MAX : Len;
        end
      end
      CAPTURE: begin
        if (abort_req)            state_next = IDLE;
        else if (len_reg == '0)   state_next = UPDATE;
        else                      state_next = SHIFT;
      end
      SHIFT: begin
        if (abort_req) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_next == len_reg) state_next = UPDATE;
        end
      end
      UPDATE:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sh_load  = (state_reg == IDLE) && Start;
  assign sh_shift = (state_reg == SHIFT) && !abort_req;
  assign sh_align = (state_reg == UPDATE);

  ijtag_shreg #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) u_shreg (
    .clk       (Clock),
    .rst_bar   (RstBar),
    .load      (sh_load),
    .shift     (sh_shift),
    .align     (sh_align),
    .load_data (WrData),
    .ser_in    (NetSO),
    .len       (len_reg),
    .ser_out   (sh_out),
    .aligned   (sh_aligned)
  );

  // Strobes and status are decoded from the next state so they change together with it.
  always_ff @(posedge Clock) begin
    if (!RstBar) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      len_reg     <= '0;
      ctrl_reg    <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      ctrl_reg  <= ctrl_for(state_next);
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
      if (state_reg == UPDATE) rd_data_reg <= sh_aligned;
    end
  end

  assign Busy      = busy_reg;
  assign Done      = done_reg;
  assign RdData    = rd_data_reg;
  assign Select    = ctrl_reg.select;
  assign CaptureEN = ctrl_reg.capture_en;
  assign ShiftEN   = ctrl_reg.shift_en;
  assign UpdateEn  = ctrl_reg.update_en;
  assign NetSI     = ctrl_reg.shift_en & sh_out;

endmodule

// File: tb/tb_ijtag_scan_driver.sv
// Directed bench for ijtag_scan_driver (MAX_LEN=8) against a serial flop-chain network model.
// Abort scenarios are compiled in when SCAN_DRV_ABORT_EN is defined.
module tb_ijtag_scan_driver;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;

  logic               Clock = 1'b0;
  logic               RstBar = 1'b0;
  logic               Start = 1'b0;
  logic [CNT_W-1:0]   Len = '0;
  logic [MAX_LEN-1:0] WrData = '0;
  logic               Busy, Done, NetSO, NetSI, Select, CaptureEN, ShiftEN, UpdateEn;
  logic [MAX_LEN-1:0] RdData;
`ifdef SCAN_DRV_ABORT_EN
  logic               Abort = 1'b0;
`endif

  ijtag_scan_driver #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .Clock     (Clock),
    .RstBar    (RstBar),
    .Start     (Start),
    .Len       (Len),
    .WrData    (WrData),
    .Busy      (Busy),
    .Done      (Done),
    .RdData    (RdData),
    .NetSO     (NetSO),
    .NetSI     (NetSI),
    .Select    (Select),
    .CaptureEN (CaptureEN),
    .ShiftEN   (ShiftEN),
    .UpdateEn  (UpdateEn)
`ifdef SCAN_DRV_ABORT_EN
    ,
    .Abort     (Abort)
`endif
  );

  always #5 Clock = ~Clock;

  // Network model: chain_n flops, SI enters at bit 0, SO is the last flop.
  logic [7:0] chain = 8'h00;
  logic [7:0] chain_init = 8'h00;
  logic       chain_load = 1'b0;
  int         chain_n = 8;

  assign NetSO = chain[3'(chain_n - 1)];

  always @(posedge Clock) begin
    if (chain_load)   chain <= chain_init;
    else if (ShiftEN) chain <= {chain[6:0], NetSI};
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  int         cap_n, shift_n, upd_n, done_n, done_cyc, multi_n, stray_n;
  logic [7:0] si_seq;
  logic       busy_c1;
  logic [6:0] post_vec;

  // One scan observed over a fixed 20-cycle window; cycle 1 is the cycle after Start is sampled.
  task automatic run_scan(input logic [3:0] len, input logic [7:0] wr, input int clen,
                          input logic [7:0] cpre, input int start_again, input int rst_at,
                          input int abort_at);
    chain_n    = clen;
    chain_init = cpre;
    chain_load = 1'b1;
    tick();
    chain_load = 1'b0;
    Len    = len;
    WrData = wr;
    Start  = 1'b1;
    tick();
    Start = 1'b0;
    cap_n = 0; shift_n = 0; upd_n = 0; done_n = 0; done_cyc = 0;
    multi_n = 0; stray_n = 0; si_seq = '0; busy_c1 = 1'b0; post_vec = '1;
    for (int c = 1; c <= 20; c++) begin
      if (CaptureEN) cap_n++;
      if (ShiftEN) begin
        if (shift_n < 8) si_seq[shift_n] = NetSI;
        shift_n++;
      end
      if (UpdateEn) upd_n++;
      if (Done) begin
        if (done_n == 0) done_cyc = c;
        done_n++;
      end
      if ((int'(CaptureEN) + int'(ShiftEN) + int'(UpdateEn)) > 1) multi_n++;
      if (!CaptureEN && !ShiftEN && !UpdateEn && (NetSI || Select)) stray_n++;
      if (c == 1) busy_c1 = Busy;
      if ((rst_at > 0 && c == rst_at + 1) || (abort_at > 0 && c == abort_at + 1))
        post_vec = {Busy, Done, Select, CaptureEN, ShiftEN, UpdateEn, NetSI};
      Start  = (c == start_again);
      RstBar = !(c == rst_at);
`ifdef SCAN_DRV_ABORT_EN
      Abort  = (c == abort_at);
`endif
      tick();
    end
    Start  = 1'b0;
    RstBar = 1'b1;
`ifdef SCAN_DRV_ABORT_EN
    Abort  = 1'b0;
`endif
  endtask

  initial begin
    // Reset held with Start asserted.
    RstBar = 1'b0; Start = 1'b1; Len = 4'd3; WrData = 8'h05;
    repeat (3) tick();
    check("reset_outputs", {57'd0, Busy, Done, Select, CaptureEN, ShiftEN, UpdateEn, NetSI}, 64'd0);
    check("reset_rddata", 64'(RdData), 64'd0);
    Start = 1'b0;
    RstBar = 1'b1;
    tick();
    $display("txn reset: outputs idle after 3 reset cycles");

    // Len=3 into a 3-flop chain preloaded 110.
    run_scan(4'd3, 8'b0000_0101, 3, 8'b0000_0110, 0, 0, 0);
    check("len3_busy_c1", 64'(busy_c1), 64'd1);
    check("len3_capture", 64'(cap_n), 64'd1);
    check("len3_shift", 64'(shift_n), 64'd3);
    check("len3_netsi", 64'(si_seq[2:0]), 64'b101);
    check("len3_update", 64'(upd_n), 64'd1);
    check("len3_done_cyc", 64'(done_cyc), 64'd6);
    check("len3_done_cnt", 64'(done_n), 64'd1);
    check("len3_rddata", 64'(RdData), 64'h03);
    check("len3_chain", 64'(chain[2:0]), 64'b101);
    check("len3_onehot", 64'(multi_n), 64'd0);
    check("len3_idle_quiet", 64'(stray_n), 64'd0);
    check("len3_busy_end", 64'(Busy), 64'd0);
    $display("txn len=3: done@%0d rd=0x%0h chain=0x%0h", done_cyc, RdData, chain[2:0]);

    // Len=0 with a Start in the DONE cycle.
    run_scan(4'd0, 8'hFF, 8, 8'hA5, 3, 0, 0);
    check("len0_capture", 64'(cap_n), 64'd1);
    check("len0_shift", 64'(shift_n), 64'd0);
    check("len0_update", 64'(upd_n), 64'd1);
    check("len0_done_cyc", 64'(done_cyc), 64'd3);
    check("len0_done_cnt", 64'(done_n), 64'd1);
    check("len0_rddata", 64'(RdData), 64'h00);
    $display("txn len=0: done@%0d rd=0x%0h", done_cyc, RdData);

    // Len=12 clamps to 8; a second Start mid-scan is dropped.
    run_scan(4'd12, 8'h35, 8, 8'h96, 4, 0, 0);
    check("len12_capture", 64'(cap_n), 64'd1);
    check("len12_shift", 64'(shift_n), 64'd8);
    check("len12_done_cyc", 64'(done_cyc), 64'd11);
    check("len12_done_cnt", 64'(done_n), 64'd1);
    check("len12_netsi", 64'(si_seq), 64'h35);
    check("len12_rddata", 64'(RdData), 64'h69);
    check("len12_chain", 64'(chain), 64'hAC);
    check("len12_onehot", 64'(multi_n), 64'd0);
    $display("txn len=12: shifts=%0d done@%0d rd=0x%0h", shift_n, done_cyc, RdData);

    // Reset during the second shift cycle.
    run_scan(4'd4, 8'h0F, 8, 8'h00, 0, 3, 0);
    check("rst_shift", 64'(shift_n), 64'd2);
    check("rst_update", 64'(upd_n), 64'd0);
    check("rst_done", 64'(done_n), 64'd0);
    check("rst_post_idle", 64'(post_vec), 64'd0);
    check("rst_rddata", 64'(RdData), 64'h00);
    $display("txn mid-scan reset: updates=%0d rd=0x%0h", upd_n, RdData);

`ifdef SCAN_DRV_ABORT_EN
    run_scan(4'd2, 8'h00, 8, 8'hC0, 0, 0, 0);
    check("pre_abort_rddata", 64'(RdData), 64'h03);
    $display("txn len=2: rd=0x%0h", RdData);
    run_scan(4'd4, 8'hFF, 8, 8'h55, 0, 0, 3);
    check("abort_update", 64'(upd_n), 64'd0);
    check("abort_done", 64'(done_n), 64'd0);
    check("abort_post_idle", 64'(post_vec), 64'd0);
    check("abort_rddata", 64'(RdData), 64'h03);
    $display("txn abort: updates=%0d rd=0x%0h", upd_n, RdData);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
